// File: rtl/nn_pkg.sv
// Shared types and constants for the neuron MAC sequencer and its mask LFSR.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mac_state_t;

    // Fibonacci taps 16,14,13,11 expressed as a mask over state bits [15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_INPUT_SIZE = 10;

endpackage

// File: rtl/neuron_mac_sequencer_if.sv
// Handshake and operand bus between the MAC sequencer, operand storage and the
// downstream activation stage. master = sequencer side, slave = environment side.
interface neuron_mac_sequencer_if
    import nn_pkg::*;
#(
    parameter int INPUT_SIZE = DEF_INPUT_SIZE,
    parameter int WIDTH      = DEF_WIDTH
);
    localparam int ADDR_W = $clog2(INPUT_SIZE);

    logic              start;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  in_data;
    logic [WIDTH-1:0]  w_data;
    logic [WIDTH-1:0]  sum;
    logic              sum_valid;
    logic              sum_ready;

    modport master (
        input  start, in_data, w_data, sum_ready,
        output busy, rd_en, rd_addr, sum, sum_valid
    );

    modport slave (
        output start, in_data, w_data, sum_ready,
        input  busy, rd_en, rd_addr, sum, sum_valid
    );

endinterface

// File: rtl/neuron_mac_sequencer_mask_lfsr.sv
// 16-bit Fibonacci LFSR supplying the random share split for the masked accumulator.
module mask_lfsr
    import nn_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    // Shift left, feeding back the XOR of the tapped bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (en) begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Sequential weighted-sum engine: streams INPUT_SIZE operand pairs through one
// shared multiply-accumulate and hands the sum downstream over valid/ready.
// Optional feature: define MAC_MASK_EN to keep the accumulator as two random shares.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; last sum held on the output
// FETCH | issuing operand reads 0..INPUT_SIZE-1, accumulating returned pairs
// DRAIN | no read; accumulating the final returned pair
// DONE  | sum_valid high until sum_ready
module neuron_mac_sequencer
    import nn_pkg::*;
#(
    parameter int          INPUT_SIZE = DEF_INPUT_SIZE,
    parameter int          WIDTH      = DEF_WIDTH,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    neuron_mac_sequencer_if.master bus
);

    localparam int                ADDR_W    = $clog2(INPUT_SIZE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(INPUT_SIZE - 1);

    // A single-pair neuron or a zero seed (masked build) would break sequencing.
    if (INPUT_SIZE < 2 || LFSR_SEED == 16'd0) begin : g_param_err
        $error("neuron_mac_sequencer: INPUT_SIZE must be >= 2 and LFSR_SEED non-zero");
    end

    mac_state_t        state;
    mac_state_t        state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              rd_q;
    logic              launch;
    logic [WIDTH-1:0]  prod;
    logic [WIDTH-1:0]  sum_total;
    logic [WIDTH-1:0]  sum_q;

    assign launch = (state == IDLE) && bus.start;

    // Only the low WIDTH bits of the product are kept, so a WIDTH-wide multiply suffices.
    assign prod = bus.in_data * bus.w_data;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start)          state_nxt = FETCH;
            FETCH:   if (cnt == LAST_ADDR)   state_nxt = DRAIN;
            DRAIN:                           state_nxt = DONE;
            DONE:    if (bus.sum_ready)      state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // Port outputs decoded from the current state.
    always_comb begin
        bus.busy      = (state != IDLE);
        bus.rd_en     = (state == FETCH);
        bus.sum_valid = (state == DONE);
        bus.rd_addr   = cnt;
        bus.sum       = sum_q;
    end

    // Operand address: cleared on launch, saturates at the last index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (launch) begin
            cnt <= '0;
        end else if (state == FETCH && cnt != LAST_ADDR) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Read strobe delayed by the storage latency marks a returned pair to accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= 1'b0;
        end else begin
            rd_q <= (state == FETCH);
        end
    end

`ifdef MAC_MASK_EN
    logic [15:0]      lfsr_state;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] share0;
    logic [WIDTH-1:0] share1;
    logic [WIDTH-1:0] share0_nxt;
    logic [WIDTH-1:0] share1_nxt;

    mask_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (state != IDLE),
        .state (lfsr_state)
    );

    assign mask_r = WIDTH'(lfsr_state);

    // Route each product to one share, chosen by the LFSR LSB.
    always_comb begin
        share0_nxt = share0;
        share1_nxt = share1;
        if (rd_q) begin
            if (lfsr_state[0]) share1_nxt = share1 + prod;
            else               share0_nxt = share0 + prod;
        end
        sum_total = share0_nxt + share1_nxt;
    end

    // Shares start as (r, -r) so their sum is zero without ever storing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            share0 <= '0;
            share1 <= '0;
        end else if (launch) begin
            share0 <= mask_r;
            share1 <= WIDTH'(0) - mask_r;
        end else begin
            share0 <= share0_nxt;
            share1 <= share1_nxt;
        end
    end
`else
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;

    // Modulo-2^WIDTH accumulate of each returned pair.
    always_comb begin
        acc_nxt   = rd_q ? (acc + prod) : acc;
        sum_total = acc_nxt;
    end

    // Accumulator register, cleared on launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (launch) begin
            acc <= '0;
        end else begin
            acc <= acc_nxt;
        end
    end
`endif

    // Result is captured as DRAIN adds the last pair and held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (state == DRAIN) begin
            sum_q <= sum_total;
        end
    end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed self-checking bench for neuron_mac_sequencer (INPUT_SIZE=10, WIDTH=16).
module tb_neuron_mac_sequencer;

    localparam int N = 10;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] in_mem [N];
    logic [W-1:0] w_mem  [N];

    neuron_mac_sequencer_if #(.INPUT_SIZE(N), .WIDTH(W)) bus ();

    neuron_mac_sequencer #(.INPUT_SIZE(N), .WIDTH(W), .LFSR_SEED(16'hACE1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Operand storage model: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.in_data <= in_mem[bus.rd_addr];
            bus.w_data  <= w_mem[bus.rd_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [W-1:0] base_in, input bit ramp, input logic [W-1:0] wv);
        for (int i = 0; i < N; i++) begin
            in_mem[i] = ramp ? W'(i + 1) : base_in;
            w_mem[i]  = wv;
        end
    endtask

    // Launch a neuron and check every cycle up to the first DONE cycle (cycle N+2).
    // pulse_cyc: FETCH cycle in which start is pulsed again (0 = never).
    task automatic run_neuron(input string tag, input logic [W-1:0] exp, input int pulse_cyc);
        bus.start = 1'b1;
        tick();
        for (int k = 1; k <= N; k++) begin
            bus.start = (k == pulse_cyc);
            check({tag, ":fetch_rd_en"},   32'(bus.rd_en),   32'd1);
            check({tag, ":fetch_rd_addr"}, 32'(bus.rd_addr), 32'(k - 1));
            check({tag, ":fetch_valid"},   32'(bus.sum_valid), 32'd0);
            tick();
        end
        bus.start = 1'b0;
        check({tag, ":drain_rd_en"}, 32'(bus.rd_en),     32'd0);
        check({tag, ":drain_busy"},  32'(bus.busy),      32'd1);
        check({tag, ":drain_valid"}, 32'(bus.sum_valid), 32'd0);
        tick();
        check({tag, ":done_valid"}, 32'(bus.sum_valid), 32'd1);
        check({tag, ":done_sum"},   32'(bus.sum),       32'(exp));
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.sum_ready = 1'b1;
        bus.in_data   = '0;
        bus.w_data    = '0;
        tick();
        tick();
        check("rst_busy",  32'(bus.busy),      32'd0);
        check("rst_rd_en", 32'(bus.rd_en),     32'd0);
        check("rst_addr",  32'(bus.rd_addr),   32'd0);
        check("rst_sum",   32'(bus.sum),       32'd0);
        check("rst_valid", 32'(bus.sum_valid), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(bus.busy), 32'd0);

        // in = 1..10, w = 2 -> 110.
        load('0, 1'b1, 16'd2);
        run_neuron("ramp", 16'h006E, 0);
        tick();
        check("ramp_idle_busy", 32'(bus.busy),      32'd0);
        check("ramp_idle_sum",  32'(bus.sum),       32'h006E);
        check("ramp_idle_vld",  32'(bus.sum_valid), 32'd0);

        // Products truncate to zero.
        load(16'h0100, 1'b0, 16'h0100);
        run_neuron("trunc", 16'h0000, 0);
        tick();

        // Ten 0xFFFF terms wrap to 0xFFF6.
        load(16'hFFFF, 1'b0, 16'h0001);
        run_neuron("wrap", 16'hFFF6, 0);
        tick();

        // Backpressure with start pulsed during DONE, including the handoff cycle.
        load('0, 1'b1, 16'd2);
        bus.sum_ready = 1'b0;
        run_neuron("bp", 16'h006E, 0);
        for (int i = 0; i < 4; i++) begin
            bus.start = (i == 1);
            tick();
            check("bp_hold_valid", 32'(bus.sum_valid), 32'd1);
            check("bp_hold_sum",   32'(bus.sum),       32'h006E);
        end
        bus.sum_ready = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        check("bp_release_busy",  32'(bus.busy),      32'd0);
        check("bp_release_valid", 32'(bus.sum_valid), 32'd0);
        tick();
        check("bp_start_ignored", 32'(bus.busy), 32'd0);

        // Reset in FETCH cycle 4 abandons the partial sum.
        load(16'hFFFF, 1'b0, 16'h0001);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        check("abort_in_fetch", 32'(bus.rd_addr), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy",  32'(bus.busy),      32'd0);
        check("abort_rd_en", 32'(bus.rd_en),     32'd0);
        check("abort_addr",  32'(bus.rd_addr),   32'd0);
        check("abort_sum",   32'(bus.sum),       32'd0);
        check("abort_valid", 32'(bus.sum_valid), 32'd0);
        load('0, 1'b1, 16'd2);
        run_neuron("post_abort", 16'h006E, 0);
        tick();

        // Start pulsed in FETCH cycle 3 yields a single result.
        run_neuron("restart", 16'h006E, 3);
        tick();
        check("restart_idle", 32'(bus.busy), 32'd0);
        tick();
        tick();
        check("restart_single", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_mac_sequencer.md
# neuron_mac_sequencer

Sequential controller that computes one neuron's weighted sum by streaming INPUT_SIZE input/weight pairs from external operand storage through a single shared multiply-accumulate. It replaces the fully parallel adder tree wherever area matters more than latency, and hands each completed sum to the downstream activation stage over a valid/ready handshake. An optional arithmetic-masking mode keeps the running accumulator split into two random shares.

## Interface
Parameters:
- INPUT_SIZE, 10, number of input/weight pairs per neuron (must be 2 or more)
- WIDTH, 16, bit width of operands, accumulator and sum
- LFSR_SEED, 16'hACE1, non-zero reset seed for the mask LFSR (used only under MAC_MASK_EN)
- ADDR_W (localparam), $clog2(INPUT_SIZE), operand address width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a neuron; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- rd_en  out  1  operand read strobe
- rd_addr  out  ADDR_W  operand index, 0 to INPUT_SIZE-1
- in_data  in  WIDTH  input operand; valid exactly one cycle after rd_en
- w_data  in  WIDTH  weight operand; valid exactly one cycle after rd_en
- sum  out  WIDTH  weighted sum, held stable while sum_valid is high
- sum_valid  out  1  result available
- sum_ready  in  1  downstream accepts the result

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE to FETCH on start. On that transition the accumulator and the address counter clear to 0.
- FETCH:
  - rd_en is high and rd_addr = counter; the counter increments every cycle.
  - Moves to DRAIN after issuing address INPUT_SIZE-1.
  - From the second FETCH cycle onward, adds in_data*w_data to the accumulator.
- DRAIN: one cycle. rd_en is low. Accumulates the final returned pair.
- DONE:
  - sum_valid is high and sum = accumulator.
  - Moves to IDLE on the cycle sum_valid && sum_ready.
  - sum keeps its value in IDLE until the next result.
- Arithmetic:
  - The product is the full 2*WIDTH-bit unsigned product, truncated to its low WIDTH bits.
  - Accumulation is unsigned modulo 2^WIDTH. No saturation, no overflow flag.
- Boundary conditions:
  - start outside IDLE is ignored. This includes the DONE cycle in which the handoff occurs; start is accepted only from the following IDLE cycle.
  - rd_addr never exceeds INPUT_SIZE-1. It resets to 0 and does not wrap during an operation.
  - Reset in any state returns to IDLE on the next edge and abandons the partial sum.
- Reset values: busy=0, rd_en=0, rd_addr=0, sum=0, sum_valid=0. Accumulator, counter and shares are 0; LFSR = LFSR_SEED.

## Timing
- Cycle 0: start sampled in IDLE.
- Cycles 1 to INPUT_SIZE: FETCH, with rd_en high.
- Cycle INPUT_SIZE+1: DRAIN.
- Cycle INPUT_SIZE+2: first DONE cycle, with sum_valid high.
- Latency from start to sum_valid is INPUT_SIZE+2 cycles; 12 at the defaults.
- With sum_ready tied high, throughput is one neuron per INPUT_SIZE+3 cycles.
- sum_valid, once asserted, stays high with sum unchanged until it is accepted.

## Configuration
- MAC_MASK_EN defined:
  - The accumulator is held as two WIDTH-bit shares. On start they clear to (r, -r), where r is the current output of a 16-bit Fibonacci LFSR (taps 16,14,13,11) truncated or zero-extended to WIDTH.
  - Each product is added to share0 when the LFSR LSB is 0, and to share1 otherwise.
  - The LFSR advances every cycle that is not in IDLE.
  - sum = share0 + share1, recombined only on entry to DONE.
  - Port-visible behaviour and latency are identical to the unmasked build.
- MAC_MASK_EN undefined: a single accumulator is used and no LFSR is instantiated.

## Structure
- Shared package nn_pkg holds:
  - the state enum mac_state_t {IDLE, FETCH, DRAIN, DONE}
  - the LFSR tap constant
  - the default WIDTH and INPUT_SIZE constants
- Sub-module mask_lfsr (seed, enable, 16-bit state output) is instantiated only under MAC_MASK_EN.
- The multiply-accumulate stays inline.

## Test plan
- in = 1..10, w = all 2, sum_ready = 1 -> sum = 110 (0x006E) with sum_valid at cycle 12; rd_addr runs 0..9 on cycles 1..10.
- in = all 0x0100, w = all 0x0100 -> every product truncates to 0 -> sum = 0. Then in = all 0xFFFF, w = all 0x0001 -> sum = 0xFFF6.
- sum_ready held low for 5 cycles after sum_valid, with start pulsed during DONE -> sum stable, start ignored, IDLE one cycle after sum_ready rises.
- rst asserted at FETCH cycle 4 -> all outputs at reset values next cycle; a new start then yields the correct sum with no residue from the aborted run.
- start pulsed at FETCH cycle 3 -> ignored; only one result is produced.
- MAC_MASK_EN build with the first vector set -> sum = 110. Internal share0 differs from the unmasked accumulator on at least one cycle.
